// File: rtl/minisrc_pkg.sv
// ============================================================================
// Module     : minisrc_pkg
// Description: Mini SRC opcodes, sequencer state codes, instruction classes,
//              ALU op select and the control strobe bundle.
//              CU_INPORT_EN adds the input-port drive strobe to the bundle.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package minisrc_pkg;

  localparam logic [4:0] c_op_ld   = 5'b00000;
  localparam logic [4:0] c_op_ldi  = 5'b00001;
  localparam logic [4:0] c_op_st   = 5'b00010;
  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_ror  = 5'b00111;
  localparam logic [4:0] c_op_rol  = 5'b01000;
  localparam logic [4:0] c_op_shr  = 5'b01001;
  localparam logic [4:0] c_op_shra = 5'b01010;
  localparam logic [4:0] c_op_shl  = 5'b01011;
  localparam logic [4:0] c_op_addi = 5'b01100;
  localparam logic [4:0] c_op_andi = 5'b01101;
  localparam logic [4:0] c_op_ori  = 5'b01110;
  localparam logic [4:0] c_op_div  = 5'b01111;
  localparam logic [4:0] c_op_mul  = 5'b10000;
  localparam logic [4:0] c_op_neg  = 5'b10001;
  localparam logic [4:0] c_op_not  = 5'b10010;
  localparam logic [4:0] c_op_br   = 5'b10011;
  localparam logic [4:0] c_op_jr   = 5'b10100;
  localparam logic [4:0] c_op_jal  = 5'b10101;
  localparam logic [4:0] c_op_in   = 5'b10110;
  localparam logic [4:0] c_op_out  = 5'b10111;
  localparam logic [4:0] c_op_mfhi = 5'b11000;
  localparam logic [4:0] c_op_mflo = 5'b11001;
  localparam logic [4:0] c_op_nop  = 5'b11010;
  localparam logic [4:0] c_op_halt = 5'b11011;

  // Tn is encoded as n+1 so a step index maps to its state by a single add.
  localparam int         c_state_w = 4;
  localparam logic [3:0] c_s_reset = 4'd0;
  localparam logic [3:0] c_s_t0    = 4'd1;
  localparam logic [3:0] c_s_t1    = 4'd2;
  localparam logic [3:0] c_s_t2    = 4'd3;
  localparam logic [3:0] c_s_t3    = 4'd4;
  localparam logic [3:0] c_s_t4    = 4'd5;
  localparam logic [3:0] c_s_t5    = 4'd6;
  localparam logic [3:0] c_s_t6    = 4'd7;
  localparam logic [3:0] c_s_t7    = 4'd8;
  localparam logic [3:0] c_s_halt  = 4'd9;

  typedef enum logic [3:0] {
    CL_ALU3, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_NEGNOT, CL_BR,
    CL_JR, CL_JAL, CL_OUT, CL_IN, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } instr_class_e;

  localparam int c_alu_n = 13;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_AND, ALU_OR, ALU_SHR,
    ALU_SHRA, ALU_SHL, ALU_ROR, ALU_ROL, ALU_NEG, ALU_NOT
  } alu_op_e;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic lo_out;
    logic hi_out;
    logic imm_out;
    logic ba_out;
    logic r_out;
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic z_in;
    logic lo_in;
    logic hi_in;
    logic r_in;
    logic con_in;
    logic outport_in;
    logic gra;
    logic grb;
    logic grc;
    logic read;
    logic write;
    logic inc_pc;
`ifdef CU_INPORT_EN
    logic inport_out;
`endif
  } ctrl_t;

  function automatic logic [c_alu_n-1:0] alu_onehot(input alu_op_e op);
    return 13'd1 << op;
  endfunction

  function automatic logic [3:0] step_state(input logic [2:0] step);
    return {1'b0, step} + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
// Module     : cu_decode
// Description: Opcode to instruction class, ALU one-hot select and last
//              execute step. CU_INPORT_EN makes the in opcode legal.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_decode
  import minisrc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic [4:0]         i_opcode,
  output instr_class_e       o_class,
  output logic [c_alu_n-1:0] o_alu_sel,
  output logic [2:0]         o_last_step
);

  alu_op_e w_alu;

  always_comb begin
    o_class = ILLEGAL_HALT ? CL_HALT : CL_NOP;
    w_alu   = ALU_ADD;
    case (i_opcode)
      c_op_ld:   o_class = CL_LD;
      c_op_ldi:  o_class = CL_LDI;
      c_op_st:   o_class = CL_ST;
      c_op_add:  o_class = CL_ALU3;
      c_op_sub:  begin o_class = CL_ALU3;   w_alu = ALU_SUB;  end
      c_op_and:  begin o_class = CL_ALU3;   w_alu = ALU_AND;  end
      c_op_or:   begin o_class = CL_ALU3;   w_alu = ALU_OR;   end
      c_op_ror:  begin o_class = CL_ALU3;   w_alu = ALU_ROR;  end
      c_op_rol:  begin o_class = CL_ALU3;   w_alu = ALU_ROL;  end
      c_op_shr:  begin o_class = CL_ALU3;   w_alu = ALU_SHR;  end
      c_op_shra: begin o_class = CL_ALU3;   w_alu = ALU_SHRA; end
      c_op_shl:  begin o_class = CL_ALU3;   w_alu = ALU_SHL;  end
      c_op_addi: o_class = CL_IMM;
      c_op_andi: begin o_class = CL_IMM;    w_alu = ALU_AND;  end
      c_op_ori:  begin o_class = CL_IMM;    w_alu = ALU_OR;   end
      c_op_div:  begin o_class = CL_MULDIV; w_alu = ALU_DIV;  end
      c_op_mul:  begin o_class = CL_MULDIV; w_alu = ALU_MUL;  end
      c_op_neg:  begin o_class = CL_NEGNOT; w_alu = ALU_NEG;  end
      c_op_not:  begin o_class = CL_NEGNOT; w_alu = ALU_NOT;  end
      c_op_br:   o_class = CL_BR;
      c_op_jr:   o_class = CL_JR;
      c_op_jal:  o_class = CL_JAL;
`ifdef CU_INPORT_EN
      c_op_in:   o_class = CL_IN;
`endif
      c_op_out:  o_class = CL_OUT;
      c_op_mfhi: o_class = CL_MFHI;
      c_op_mflo: o_class = CL_MFLO;
      c_op_nop:  o_class = CL_NOP;
      c_op_halt: o_class = CL_HALT;
      default:   ;
    endcase
  end

  assign o_alu_sel = alu_onehot(w_alu);

  always_comb begin
    case (o_class)
      CL_ALU3, CL_IMM, CL_LDI:   o_last_step = 3'd5;
      CL_LD:                     o_last_step = 3'd7;
      CL_ST, CL_MULDIV, CL_BR:   o_last_step = 3'd6;
      CL_NEGNOT, CL_JAL:         o_last_step = 3'd4;
      default:                   o_last_step = 3'd3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module     : control_unit
// Description: Hardwired Mini SRC sequencer: fetch T0-T2, opcode-driven
//              execute T3-T7. CU_INPORT_EN adds the InPortout strobe and the
//              in instruction.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
  import minisrc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        BranchOut,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        LOout,
  output logic        HIout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        LOin,
  output logic        HIin,
  output logic        Rin,
  output logic        CONin,
  output logic        OutPortIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT
`ifdef CU_INPORT_EN
  ,
  output logic        InPortout
`endif
);

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_next;
  instr_class_e         w_class;
  logic [c_alu_n-1:0]   w_alu_sel;
  logic [c_alu_n-1:0]   w_alu;
  logic [2:0]           w_last_step;
  logic                 w_at_last;
  logic                 w_op_step;
  logic                 w_run;
  ctrl_t                w_ctrl;
  logic                 w_unused_ir;

  assign w_unused_ir = ^IR[26:0];

  cu_decode #(
    .ILLEGAL_HALT (ILLEGAL_HALT)
  ) u_decode (
    .i_opcode    (IR[31:27]),
    .o_class     (w_class),
    .o_alu_sel   (w_alu_sel),
    .o_last_step (w_last_step)
  );

  assign w_at_last = (r_state == step_state(w_last_step));
  assign w_run     = (r_state >= c_s_t0) && (r_state <= c_s_t7);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) r_state <= c_s_reset;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_s_reset: w_state_next = c_s_t0;
      c_s_t0:    w_state_next = c_s_t1;
      c_s_t1:    w_state_next = c_s_t2;
      c_s_t2:    w_state_next = c_s_t3;
      c_s_t3, c_s_t4, c_s_t5, c_s_t6, c_s_t7: begin
        if (w_class == CL_HALT)  w_state_next = c_s_halt;
        else if (w_at_last)      w_state_next = Stop ? c_s_halt : c_s_t0;
        else                     w_state_next = r_state + 4'd1;
      end
      c_s_halt:  w_state_next = c_s_halt;
      default:   w_state_next = c_s_reset;
    endcase
  end

  // Execute strobes; w_op_step marks the step whose Zin captures the decoded op.
  always_comb begin
    w_ctrl    = '0;
    w_op_step = 1'b0;
    case (r_state)
      c_s_t0: begin
        w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1;
        w_ctrl.inc_pc = 1'b1; w_ctrl.z_in   = 1'b1;
      end
      c_s_t1: begin
        w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in  = 1'b1;
        w_ctrl.read     = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      c_s_t2: begin
        w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
      end
      c_s_t3, c_s_t4, c_s_t5, c_s_t6, c_s_t7: begin
        case (w_class)
          CL_ALU3, CL_IMM: begin
            if (r_state == c_s_t3) begin
              w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1;
            end
            if (r_state == c_s_t4) begin
              w_ctrl.grc     = (w_class == CL_ALU3);
              w_ctrl.r_out   = (w_class == CL_ALU3);
              w_ctrl.imm_out = (w_class == CL_IMM);
              w_ctrl.z_in    = 1'b1;
              w_op_step      = 1'b1;
            end
            if (r_state == c_s_t5) begin
              w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
            end
          end
          CL_LDI, CL_LD, CL_ST: begin
            if (r_state == c_s_t3) begin
              w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
            end
            if (r_state == c_s_t4) begin
              w_ctrl.imm_out = 1'b1; w_ctrl.z_in = 1'b1; w_op_step = 1'b1;
            end
            if (r_state == c_s_t5) begin
              w_ctrl.zlow_out = 1'b1;
              w_ctrl.gra      = (w_class == CL_LDI);
              w_ctrl.r_in     = (w_class == CL_LDI);
              w_ctrl.mar_in   = (w_class != CL_LDI);
            end
            if (r_state == c_s_t6) begin
              w_ctrl.read   = (w_class == CL_LD);
              w_ctrl.mdr_in = (w_class == CL_LD);
              w_ctrl.gra    = (w_class == CL_ST);
              w_ctrl.r_out  = (w_class == CL_ST);
              w_ctrl.write  = (w_class == CL_ST);
            end
            if (r_state == c_s_t7) begin
              w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
            end
          end
          CL_MULDIV: begin
            if (r_state == c_s_t3) begin
              w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1;
            end
            if (r_state == c_s_t4) begin
              w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.z_in = 1'b1;
              w_op_step  = 1'b1;
            end
            if (r_state == c_s_t5) begin
              w_ctrl.zlow_out = 1'b1; w_ctrl.lo_in = 1'b1;
            end
            if (r_state == c_s_t6) begin
              w_ctrl.zhigh_out = 1'b1; w_ctrl.hi_in = 1'b1;
            end
          end
          CL_NEGNOT: begin
            if (r_state == c_s_t3) begin
              w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.z_in = 1'b1;
              w_op_step  = 1'b1;
            end
            if (r_state == c_s_t4) begin
              w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
            end
          end
          CL_BR: begin
            if (r_state == c_s_t3) begin
              w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.con_in = 1'b1;
            end
            if (r_state == c_s_t4) begin
              w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1;
            end
            if (r_state == c_s_t5) begin
              w_ctrl.imm_out = 1'b1; w_ctrl.z_in = 1'b1;
            end
            if (r_state == c_s_t6) begin
              w_ctrl.zlow_out = BranchOut; w_ctrl.pc_in = BranchOut;
            end
          end
          CL_JR: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1;
          end
          CL_JAL: begin
            if (r_state == c_s_t3) begin
              w_ctrl.pc_out = 1'b1; w_ctrl.grb = 1'b1; w_ctrl.r_in = 1'b1;
            end
            if (r_state == c_s_t4) begin
              w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1;
            end
          end
          CL_OUT: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.outport_in = 1'b1;
          end
`ifdef CU_INPORT_EN
          CL_IN: begin
            w_ctrl.inport_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
`endif
          CL_MFHI: begin
            w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          CL_MFLO: begin
            w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // ADD is the resting ALU select whenever sequencing; idle steps keep it.
  assign w_alu = !w_run   ? '0 :
                 w_op_step ? w_alu_sel : alu_onehot(ALU_ADD);

  assign Run       = w_run;
  assign PCout     = w_ctrl.pc_out;
  assign Zlowout   = w_ctrl.zlow_out;
  assign Zhighout  = w_ctrl.zhigh_out;
  assign MDRout    = w_ctrl.mdr_out;
  assign LOout     = w_ctrl.lo_out;
  assign HIout     = w_ctrl.hi_out;
  assign Cout      = w_ctrl.imm_out;
  assign BAout     = w_ctrl.ba_out;
  assign Rout      = w_ctrl.r_out;
  assign PCin      = w_ctrl.pc_in;
  assign IRin      = w_ctrl.ir_in;
  assign MARin     = w_ctrl.mar_in;
  assign MDRin     = w_ctrl.mdr_in;
  assign Yin       = w_ctrl.y_in;
  assign Zin       = w_ctrl.z_in;
  assign LOin      = w_ctrl.lo_in;
  assign HIin      = w_ctrl.hi_in;
  assign Rin       = w_ctrl.r_in;
  assign CONin     = w_ctrl.con_in;
  assign OutPortIn = w_ctrl.outport_in;
  assign Gra       = w_ctrl.gra;
  assign Grb       = w_ctrl.grb;
  assign Grc       = w_ctrl.grc;
  assign Read      = w_ctrl.read;
  assign Write     = w_ctrl.write;
  assign IncPC     = w_ctrl.inc_pc;
`ifdef CU_INPORT_EN
  assign InPortout = w_ctrl.inport_out;
`endif

  assign {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, DIV, MUL, SUB, ADD} = w_alu;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module     : tb_control_unit
// Description: Self-checking bench for control_unit: step-table reference
//              model, directed scenarios and randomized instruction streams.
//              Honours CU_INPORT_EN when defined.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  localparam bit ILLEGAL_HALT = 1'b0;
`ifdef CU_INPORT_EN
  localparam bit INP = 1'b1;
`else
  localparam bit INP = 1'b0;
`endif

  localparam int P_RUN = 0, P_PCOUT = 1, P_ZLOW = 2, P_ZHIGH = 3, P_MDROUT = 4;
  localparam int P_LOOUT = 5, P_HIOUT = 6, P_COUT = 7, P_BAOUT = 8, P_ROUT = 9;
  localparam int P_PCIN = 10, P_IRIN = 11, P_MARIN = 12, P_MDRIN = 13, P_YIN = 14;
  localparam int P_ZIN = 15, P_LOIN = 16, P_HIIN = 17, P_RIN = 18, P_CONIN = 19;
  localparam int P_OUTIN = 20, P_GRA = 21, P_GRB = 22, P_GRC = 23, P_READ = 24;
  localparam int P_WRITE = 25, P_INCPC = 26, P_ADD = 27, P_SUB = 28, P_MUL = 29;
  localparam int P_DIV = 30, P_AND = 31, P_OR = 32, P_SHR = 33, P_SHRA = 34;
  localparam int P_SHL = 35, P_ROR = 36, P_ROL = 37, P_NEG = 38, P_NOT = 39;
  localparam int P_INP = 40;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        BranchOut = 1'b0;
  logic        Stop = 1'b0;
  logic Run, PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin, CONin, OutPortIn;
  logic Gra, Grb, Grc, Read, Write, IncPC;
  logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic InPortout;
  logic [40:0] dut_vec;

  int n_vec = 0;
  int n_bad = 0;
  int mphase = 0;  // 0 reset, 1 sequencing, 2 halted
  int mstep  = 0;

  control_unit #(.ILLEGAL_HALT(ILLEGAL_HALT)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .BranchOut(BranchOut), .Stop(Stop),
    .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .LOout(LOout), .HIout(HIout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin), .Rin(Rin), .CONin(CONin),
    .OutPortIn(OutPortIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read),
    .Write(Write), .IncPC(IncPC), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR),
    .ROL(ROL), .NEG(NEG), .NOT(NOT)
`ifdef CU_INPORT_EN
    , .InPortout(InPortout)
`endif
  );

`ifndef CU_INPORT_EN
  assign InPortout = 1'b0;
`endif

  assign dut_vec = {InPortout, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, DIV,
                    MUL, SUB, ADD, IncPC, Write, Read, Grc, Grb, Gra, OutPortIn,
                    CONin, Rin, HIin, LOin, Zin, Yin, MDRin, MARin, IRin, PCin,
                    Rout, BAout, Cout, HIout, LOout, MDRout, Zhighout, Zlowout,
                    PCout, Run};

  always #5 Clock = ~Clock;

  function automatic logic [40:0] m(int a, int b = -1, int c = -1, int d = -1);
    logic [40:0] v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  function automatic bit op_defined(logic [4:0] op);
    return (op <= 5'd27) && !(op == 5'd22 && !INP);
  endfunction

  function automatic bit op_halts(logic [4:0] op);
    return (op == 5'd27) || (!op_defined(op) && ILLEGAL_HALT);
  endfunction

  function automatic int last_step(logic [4:0] op);
    case (op)
      5'd0:                                  return 7;
      5'd2, 5'd15, 5'd16, 5'd19:             return 6;
      5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: return 5;
      5'd17, 5'd18, 5'd21:                   return 4;
      default:                               return 3;
    endcase
  endfunction

  function automatic int alu_bit(logic [4:0] op);
    case (op)
      5'd4:         return P_SUB;
      5'd5, 5'd13:  return P_AND;
      5'd6, 5'd14:  return P_OR;
      5'd7:         return P_ROR;
      5'd8:         return P_ROL;
      5'd9:         return P_SHR;
      5'd10:        return P_SHRA;
      5'd11:        return P_SHL;
      5'd15:        return P_DIV;
      5'd16:        return P_MUL;
      5'd17:        return P_NEG;
      5'd18:        return P_NOT;
      default:      return P_ADD;
    endcase
  endfunction

  // Expected outputs from the instruction step tables; ADD rests when no op applies.
  function automatic logic [40:0] exp_vec(int ph, int st, logic [4:0] op, logic bo);
    logic [40:0] v;
    int alu = P_ADD;
    if (ph != 1) return '0;
    v = m(P_RUN);
    if (st == 0)      v |= m(P_PCOUT, P_MARIN, P_INCPC, P_ZIN);
    else if (st == 1) v |= m(P_ZLOW, P_PCIN, P_READ, P_MDRIN);
    else if (st == 2) v |= m(P_MDROUT, P_IRIN);
    else begin
      case (op)
        5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: begin
          if (st == 3) v |= m(P_GRB, P_ROUT, P_YIN);
          if (st == 4) begin
            v |= (op >= 5'd12) ? m(P_COUT, P_ZIN) : m(P_GRC, P_ROUT, P_ZIN);
            alu = alu_bit(op);
          end
          if (st == 5) v |= m(P_ZLOW, P_GRA, P_RIN);
        end
        5'd0, 5'd1, 5'd2: begin
          if (st == 3) v |= m(P_GRB, P_BAOUT, P_YIN);
          if (st == 4) v |= m(P_COUT, P_ZIN);
          if (st == 5) v |= (op == 5'd1) ? m(P_ZLOW, P_GRA, P_RIN) : m(P_ZLOW, P_MARIN);
          if (st == 6) v |= (op == 5'd0) ? m(P_READ, P_MDRIN) : m(P_GRA, P_ROUT, P_WRITE);
          if (st == 7) v |= m(P_MDROUT, P_GRA, P_RIN);
        end
        5'd15, 5'd16: begin
          if (st == 3) v |= m(P_GRA, P_ROUT, P_YIN);
          if (st == 4) begin v |= m(P_GRB, P_ROUT, P_ZIN); alu = alu_bit(op); end
          if (st == 5) v |= m(P_ZLOW, P_LOIN);
          if (st == 6) v |= m(P_ZHIGH, P_HIIN);
        end
        5'd17, 5'd18: begin
          if (st == 3) begin v |= m(P_GRB, P_ROUT, P_ZIN); alu = alu_bit(op); end
          if (st == 4) v |= m(P_ZLOW, P_GRA, P_RIN);
        end
        5'd19: begin
          if (st == 3) v |= m(P_GRA, P_ROUT, P_CONIN);
          if (st == 4) v |= m(P_PCOUT, P_YIN);
          if (st == 5) v |= m(P_COUT, P_ZIN);
          if (st == 6 && bo) v |= m(P_ZLOW, P_PCIN);
        end
        5'd20: v |= m(P_GRA, P_ROUT, P_PCIN);
        5'd21: v |= (st == 3) ? m(P_PCOUT, P_GRB, P_RIN) : m(P_GRA, P_ROUT, P_PCIN);
        5'd22: if (INP) v |= m(P_INP, P_GRA, P_RIN);
        5'd23: v |= m(P_GRA, P_ROUT, P_OUTIN);
        5'd24: v |= m(P_HIOUT, P_GRA, P_RIN);
        5'd25: v |= m(P_LOOUT, P_GRA, P_RIN);
        default: ;
      endcase
    end
    v[alu] = 1'b1;
    return v;
  endfunction

  always @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      mphase <= 0; mstep <= 0;
    end else if (mphase == 0) begin
      mphase <= 1; mstep <= 0;
    end else if (mphase == 1) begin
      if (mstep < 3)                         mstep <= mstep + 1;
      else if (op_halts(IR[31:27]))          mphase <= 2;
      else if (mstep >= last_step(IR[31:27])) begin
        if (Stop) mphase <= 2;
        else      mstep <= 0;
      end else                               mstep <= mstep + 1;
    end
  end

  always @(negedge Clock) begin
    logic [40:0] e;
    e = exp_vec(mphase, mstep, IR[31:27], BranchOut);
    n_vec++;
    if (dut_vec !== e) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t phase=%0d step=%0d op=%b got=%h want=%h",
               $time, mphase, mstep, IR[31:27], dut_vec, e);
    end
    if (Run === 1'b1) begin
      n_vec++;
      if ($countones(dut_vec[39:27]) != 1) begin
        n_bad++;
        $display("FAIL alu_onehot t=%0t got=%b want exactly one bit", $time, dut_vec[39:27]);
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [40:0] want);
    n_vec++;
    if (dut_vec !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, dut_vec, want);
    end
  endtask

  // From T0, fetch with garbage IR and present the real instruction during T2.
  task automatic fetch_to(input logic [31:0] ir);
    IR = $urandom; cyc();
    IR = $urandom; cyc();
    IR = ir;       cyc();
  endtask

  task automatic recover();
    Clear = 1'b1; cyc();
    Clear = 1'b0; Stop = 1'b0; cyc();
  endtask

  logic [40:0] t0v, idle;

  initial begin
    t0v  = m(P_RUN, P_PCOUT, P_MARIN, P_INCPC) | m(P_ZIN, P_ADD);
    idle = m(P_RUN, P_ADD);
    #1 Clear = 1'b1;
    cyc(); cyc();
    chk("reset_hold", '0);
    Clear = 1'b0; cyc();
    chk("leave_reset_t0", t0v);

    fetch_to(32'h1A920000);
    chk("add_t3", m(P_RUN, P_GRB, P_ROUT, P_YIN) | m(P_ADD));
    cyc(); chk("add_t4", m(P_RUN, P_GRC, P_ROUT, P_ZIN) | m(P_ADD));
    cyc(); chk("add_t5", m(P_RUN, P_ZLOW, P_GRA, P_RIN) | m(P_ADD));
    cyc(); chk("add_next_t0", t0v);

    fetch_to({5'b00000, 27'h0123456});
    cyc(); cyc(); cyc();
    chk("ld_t6", m(P_RUN, P_READ, P_MDRIN, P_ADD));
    cyc(); chk("ld_t7", m(P_RUN, P_MDROUT, P_GRA, P_RIN) | m(P_ADD));
    cyc(); chk("ld_8cyc_t0", t0v);

    BranchOut = 1'b0;
    fetch_to({5'b10011, 27'h0});
    cyc(); cyc(); cyc(); chk("br0_t6", idle);
    cyc(); chk("br0_t0", t0v);
    BranchOut = 1'b1;
    fetch_to({5'b10011, 27'h0});
    cyc(); cyc(); cyc(); chk("br1_t6", m(P_RUN, P_ZLOW, P_PCIN, P_ADD));
    cyc(); BranchOut = 1'b0;

    fetch_to({5'b10000, 27'h0});
    cyc(); chk("mul_t4", m(P_RUN, P_GRB, P_ROUT, P_ZIN) | m(P_MUL));
    cyc(); chk("mul_t5", m(P_RUN, P_ZLOW, P_LOIN, P_ADD));
    cyc(); chk("mul_t6", m(P_RUN, P_ZHIGH, P_HIIN, P_ADD));
    cyc();

    fetch_to(32'h1A920000);
    cyc(); Clear = 1'b1; #1;
    chk("clear_mid_t4", '0);
    cyc(); chk("clear_held", '0);
    Clear = 1'b0; cyc(); chk("clear_restart_t0", t0v);

    fetch_to(32'h1A920000);
    cyc(); Stop = 1'b1;
    cyc(); cyc(); chk("stop_halt", '0);
    Stop = 1'b0;
    repeat (20) cyc();
    chk("halt_sticky", '0);
    recover(); chk("halt_recover_t0", t0v);

    fetch_to({5'b11011, 27'h0});
    chk("halt_op_t3", idle);
    cyc(); chk("halt_op_halted", '0);
    recover();

    fetch_to({5'b11111, 27'h0});
    chk("undef_t3_nop", idle);
    cyc(); chk("undef_next_t0", t0v);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] op;
      int n;
      op = 5'($urandom_range(0, 31));
      n  = 0;
      do begin
        BranchOut = 1'($urandom);
        Stop      = ($urandom_range(0, 19) == 0);
        if (mphase == 1 && mstep == 2)     IR = {op, 27'($urandom)};
        else if (mphase != 1 || mstep < 2) IR = $urandom;
        if ($urandom_range(0, 199) == 0) begin
          Clear = 1'b1; #1; Clear = 1'b0;
        end
        cyc();
        n++;
      end while (mphase == 1 && mstep != 0 && n < 20);
      if (mphase == 1 && mstep != 0) begin
        n_vec++; n_bad++;
        $display("FAIL random_timeout: instr %0d op=%b still at step %0d after %0d cycles",
                 i, op, mstep, n);
      end
      if (mphase != 1 || mstep != 0) recover();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
